// File: rtl/handshake_pack.sv
// handshake_pack
//   Packs RATIO consecutive WIDTH-bit beats from a valid/ready stream into one
//   WIDTH*RATIO-bit word. A beat flagged with i_last closes the word early.
//   Lanes that did not receive a beat read as zero and are cleared in o_keep.
//   The first beat of a word lands in lane 0 (bits [WIDTH-1:0]).
//
// Ports
//   clock    in   rising-edge clock for all state
//   reset    in   asynchronous, active-high reset
//   i_value  in   [WIDTH]        input beat data
//   i_valid  in   input beat valid
//   i_last   in   beat closes the current word (sampled only on accept)
//   o_ready  out  input beat is accepted this cycle when i_valid is high
//   o_value  out  [WIDTH*RATIO]  packed word, lane k = [k*WIDTH +: WIDTH]
//   o_keep   out  [RATIO]        bit k set = lane k holds a beat
//   o_last   out  word was closed by i_last
//   o_valid  out  output word valid
//   i_ready  in   downstream accepts the output word
//
// o_ready is a function of registered o_valid and i_ready only, so the input
// side never sees a combinational path from i_valid/i_value/i_last.

module handshake_pack #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         i_value,
  input  logic                     i_valid,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic [WIDTH*RATIO-1:0]   o_value,
  output logic [RATIO-1:0]         o_keep,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready
);

  localparam int CNT_W = $clog2(RATIO);
  localparam int ACC_W = WIDTH * (RATIO - 1);

  // Mask with lanes 0..last_lane set.
  function automatic logic [RATIO-1:0] keep_mask(input logic [CNT_W-1:0] last_lane);
    logic [RATIO-1:0] m;
    m = '0;
    for (int k = 0; k < RATIO; k++) begin
      m[k] = (k <= int'(last_lane));
    end
    return m;
  endfunction

  logic [ACC_W-1:0]       acc;
  logic [CNT_W-1:0]       cnt;

  logic                   accept;
  logic                   complete;
  logic                   top_lane;
  logic [ACC_W-1:0]       acc_nxt;
  logic [WIDTH*RATIO-1:0] word_nxt;

  // Stage 0: input handshake and lane accumulation
  assign o_ready  = ~o_valid | i_ready;
  assign accept   = i_valid & o_ready;
  assign top_lane = (cnt == CNT_W'(RATIO - 1));
  assign complete = accept & (top_lane | i_last);

  // Beat written into its lane of the accumulator. The top lane is never
  // stored here: a beat arriving at cnt == RATIO-1 always completes the word
  // and goes straight into the output register.
  always_comb begin
    acc_nxt = acc;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (k == int'(cnt)) begin
        acc_nxt[k*WIDTH +: WIDTH] = i_value;
      end
    end
  end

  // Completed word: lanes below cnt from the accumulator, lane cnt from the
  // current beat, lanes above cnt zero.
  always_comb begin
    word_nxt = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (k < int'(cnt)) begin
        word_nxt[k*WIDTH +: WIDTH] = acc[k*WIDTH +: WIDTH];
      end
    end
    for (int k = 0; k < RATIO; k++) begin
      if (k == int'(cnt)) begin
        word_nxt[k*WIDTH +: WIDTH] = i_value;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (complete) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_nxt;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Stage 1: output word register
  // A complete in the same cycle as a drain simply overwrites the word and
  // keeps o_valid high, so back-to-back words leave no bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_value <= '0;
      o_keep  <= '0;
      o_last  <= 1'b0;
      o_valid <= 1'b0;
    end else if (complete) begin
      o_value <= word_nxt;
      o_keep  <= keep_mask(cnt);
      o_last  <= i_last;
      o_valid <= 1'b1;
    end else if (o_valid & i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_handshake_pack.sv
// tb_handshake_pack
//   Directed bench for handshake_pack with default parameters (8-bit lanes,
//   4 lanes). Expected words are written out by hand; a negedge monitor
//   records every word handed downstream for the ordering/loss checks.

module tb_handshake_pack;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  i_value = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic [31:0] o_value;
  logic [3:0]  o_keep;
  logic        o_last;
  logic        o_valid;
  logic        i_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic toggle_en = 1'b0;

  logic [31:0] cap_v[$];
  logic [3:0]  cap_k[$];
  logic        cap_l[$];
  int          cap_c[$];

  handshake_pack #(.WIDTH(8), .RATIO(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_value (i_value),
    .i_valid (i_valid),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_value (o_value),
    .o_keep  (o_keep),
    .o_last  (o_last),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record each word at the point it is handed over downstream.
  always @(negedge clock) begin
    if (!reset && o_valid && i_ready) begin
      cap_v.push_back(o_value);
      cap_k.push_back(o_keep);
      cap_l.push_back(o_last);
      cap_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one beat and return #1 after the edge that accepts it.
  task automatic send(input logic [7:0] v, input logic l);
    bit done;
    done = 1'b0;
    i_valid = 1'b1;
    i_value = v;
    i_last  = l;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clock);
      if (o_ready) begin
        @(posedge clock);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_last  = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_cap();
    cap_v.delete();
    cap_k.delete();
    cap_l.delete();
    cap_c.delete();
  endtask

  logic [31:0] stream_w[4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
  logic [31:0] stall_w[3]  = '{32'h13121110, 32'h23222120, 32'h27262524};

  initial begin
    // Reset state
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_value", o_value, 0);
    chk("rst_keep",  o_keep, 0);
    chk("rst_last",  o_last, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    reset = 1'b0;
    @(posedge clock); #1;

    // Full word, o_ready high throughout
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("full_early_valid", o_valid, 0);
    send(8'h44, 1'b0);
    i_valid = 1'b0;
    @(negedge clock);
    chk("full_value", o_value, 32'h44332211);
    chk("full_keep",  o_keep, 4'b1111);
    chk("full_last",  o_last, 0);
    chk("full_valid", o_valid, 1);
    chk("full_ready", o_ready, 1);
    @(negedge clock);
    chk("full_pulse_end", o_valid, 0);
    chk("full_hold_value", o_value, 32'h44332211);

    // Two-beat word closed by i_last
    @(posedge clock); #1;
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b1);
    i_valid = 1'b0;
    @(negedge clock);
    chk("last2_value", o_value, 32'h0000B2A1);
    chk("last2_keep",  o_keep, 4'b0011);
    chk("last2_last",  o_last, 1);
    chk("last2_valid", o_valid, 1);

    // Single beat with i_last lands in lane 0
    @(posedge clock); #1;
    send(8'h5C, 1'b1);
    i_valid = 1'b0;
    @(negedge clock);
    chk("last1_value", o_value, 32'h0000005C);
    chk("last1_keep",  o_keep, 4'b0001);
    chk("last1_last",  o_last, 1);

    // i_last on the top lane
    @(posedge clock); #1;
    send(8'hD0, 1'b0);
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b1);
    i_valid = 1'b0;
    @(negedge clock);
    chk("last4_value", o_value, 32'hD3D2D1D0);
    chk("last4_keep",  o_keep, 4'b1111);
    chk("last4_last",  o_last, 1);
    @(posedge clock); #1;

    // Stall: word held while 8 beats are offered and refused
    clear_cap();
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    i_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      i_valid = 1'b1;
      i_value = 8'hE0 + 8'(k);
      i_last  = k[0];
      @(negedge clock);
      chk("stall_ready", o_ready, 0);
      chk("stall_valid", o_valid, 1);
      chk("stall_value", o_value, 32'h13121110);
      @(posedge clock); #1;
    end
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(8'h20 + 8'(k), 1'b0);
    idle(3);
    chk("stall_count", cap_v.size(), 3);
    for (int k = 0; k < 3 && k < cap_v.size(); k++) begin
      chk("stall_word", cap_v[k], stall_w[k]);
      chk("stall_keep", cap_k[k], 4'b1111);
    end

    // Continuous stream, back-to-back words every 4 cycles
    clear_cap();
    for (int k = 0; k < 16; k++) send(8'(k), 1'b0);
    idle(3);
    chk("stream_count", cap_v.size(), 4);
    for (int k = 0; k < 4 && k < cap_v.size(); k++) begin
      chk("stream_word", cap_v[k], stream_w[k]);
      chk("stream_last", cap_l[k], 0);
    end
    for (int k = 0; k < 3 && k + 1 < cap_c.size(); k++)
      chk("stream_spacing", cap_c[k+1] - cap_c[k], 4);

    // Same stream with i_ready toggling every cycle
    clear_cap();
    toggle_en = 1'b1;
    fork
      begin
        while (toggle_en) begin
          @(posedge clock); #1;
          i_ready = ~i_ready;
        end
      end
    join_none
    for (int k = 0; k < 16; k++) send(8'(k), 1'b0);
    idle(6);
    toggle_en = 1'b0;
    @(posedge clock); #1;
    i_ready = 1'b1;
    idle(3);
    chk("toggle_count", cap_v.size(), 4);
    for (int k = 0; k < 4 && k < cap_v.size(); k++)
      chk("toggle_word", cap_v[k], stream_w[k]);

    // Reset mid-word discards the partial word
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    i_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_value", o_value, 0);
    chk("midrst_keep",  o_keep, 0);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_last",  o_last, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    clear_cap();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    idle(3);
    chk("midrst_count", cap_v.size(), 1);
    if (cap_v.size() > 0) chk("midrst_word", cap_v[0], 32'h04030201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
